// File: rtl/sr_word_serializer.sv
// Parallel-to-serial feeder for a bidirectional shift register: each accepted word is
// streamed one bit per clock so the downstream register ends up holding the word intact.
module sr_word_serializer #(
   parameter int WIDTH = 16,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             sr_d,
   output logic             sr_en,
   output logic             sr_dir,
   output logic             busy,
   output logic             done
);
   localparam int CNT_W = ($clog2(WIDTH + 1) > 8) ? $clog2(WIDTH + 1) : 8;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_GAP = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t           r_state,    w_state_next;
   logic [CNT_W-1:0] r_cnt,      w_cnt_next;
   logic [WIDTH-1:0] r_word,     w_word_next;
   logic             r_sr_d,     w_sr_d_next;
   logic             r_sr_en,    w_sr_en_next;
   logic             r_sr_dir,   w_sr_dir_next;
   logic             r_busy,     w_busy_next;
   logic             r_done,     w_done_next;
   logic             r_in_ready, w_in_ready_next;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_word     <= '0;
         r_sr_d     <= 1'b0;
         r_sr_en    <= 1'b0;
         r_sr_dir   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_word     <= w_word_next;
         r_sr_d     <= w_sr_d_next;
         r_sr_en    <= w_sr_en_next;
         r_sr_dir   <= w_sr_dir_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_in_ready <= w_in_ready_next;
      end
   end

   // The hold register shifts toward the outgoing end so the next bit is always at
   // bit 0 (LSB-first words) or at the MSB (MSB-first words).
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_word_next     = r_word;
      w_sr_d_next     = 1'b0;
      w_sr_en_next    = 1'b0;
      w_sr_dir_next   = r_sr_dir;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
      w_in_ready_next = r_in_ready;
      case (r_state)
         ST_IDLE: begin
            w_in_ready_next = 1'b1;
            w_busy_next     = 1'b0;
            if (in_valid && r_in_ready && !flush) begin
               w_state_next    = ST_SHIFT;
               w_cnt_next      = '0;
               w_sr_dir_next   = in_dir;
               w_sr_en_next    = 1'b1;
               w_sr_d_next     = in_dir ? in_data[0] : in_data[WIDTH-1];
               w_word_next     = in_dir ? {1'b0, in_data[WIDTH-1:1]}
                                        : {in_data[WIDTH-2:0], 1'b0};
               w_in_ready_next = 1'b0;
               w_busy_next     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (flush) begin
               w_state_next    = ST_IDLE;
               w_cnt_next      = '0;
               w_busy_next     = 1'b0;
               w_in_ready_next = 1'b1;
            end else if (r_cnt == LAST_BIT) begin
               w_done_next = 1'b1;
               w_cnt_next  = '0;
               if (GAP == 0) begin
                  w_state_next    = ST_IDLE;
                  w_busy_next     = 1'b0;
                  w_in_ready_next = 1'b1;
               end else begin
                  w_state_next = ST_GAP;
               end
            end else begin
               w_cnt_next   = r_cnt + ONE;
               w_sr_en_next = 1'b1;
               w_sr_d_next  = r_sr_dir ? r_word[0] : r_word[WIDTH-1];
               w_word_next  = r_sr_dir ? {1'b0, r_word[WIDTH-1:1]}
                                       : {r_word[WIDTH-2:0], 1'b0};
            end
         end
         ST_GAP: begin
            if (flush || r_cnt == LAST_GAP) begin
               w_state_next    = ST_IDLE;
               w_cnt_next      = '0;
               w_busy_next     = 1'b0;
               w_in_ready_next = 1'b1;
            end else begin
               w_cnt_next = r_cnt + ONE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign in_ready = r_in_ready;
   assign sr_d     = r_sr_d;
   assign sr_en    = r_sr_en;
   assign sr_dir   = r_sr_dir;
   assign busy     = r_busy;
   assign done     = r_done;
endmodule

// File: tb/tb_sr_word_serializer.sv
// Bench for sr_word_serializer: two instances (GAP=0 and GAP=3) each feeding a model of the
// downstream shift register; a scoreboard checks every completed word against the source word.
module tb_sr_word_serializer;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] data;
      logic         dir;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int fin_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int G = (gi == 0) ? 0 : 3;

      logic         rstn, in_valid, in_dir, flush;
      logic [W-1:0] in_data;
      logic         in_ready, sr_d, sr_en, sr_dir, busy, done;
      logic [W-1:0] sr_out;
      exp_t         sb[$];

      sr_word_serializer #(.WIDTH(W), .GAP(G)) u_dut (
         .clk      (clk),
         .rstn     (rstn),
         .in_data  (in_data),
         .in_dir   (in_dir),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .flush    (flush),
         .sr_d     (sr_d),
         .sr_en    (sr_en),
         .sr_dir   (sr_dir),
         .busy     (busy),
         .done     (done)
      );

      // Downstream register: dir=0 enters at bit 0 and shifts up, dir=1 enters at the MSB.
      always @(posedge clk) begin
         if (sr_en) sr_out <= sr_dir ? {sr_d, sr_out[W-1:1]} : {sr_out[W-2:0], sr_d};
      end

      function automatic string nm(input string s);
         return $sformatf("g%0d_%s", G, s);
      endfunction

      // Monitor: collect serial bits, and on each done pulse compare against the scoreboard.
      initial begin
         logic [W-1:0] got, exp_s;
         int           nbits;
         logic         prev_done;
         exp_t         e;
         got = '0;
         nbits = 0;
         prev_done = 1'b0;
         forever begin
            @(negedge clk);
            if (!rstn) begin
               nbits = 0;
               prev_done = 1'b0;
            end else begin
               if (done) check(nm("done_pulse_width"), prev_done, 1'b0);
               if (sr_en) begin
                  got = {got[W-2:0], sr_d};
                  nbits++;
               end else begin
                  if (done) begin
                     if (sb.size() == 0) begin
                        check(nm("done_without_word"), 1, 0);
                     end else begin
                        e = sb.pop_front();
                        exp_s = e.data;
                        if (e.dir) for (int j = 0; j < W; j++) exp_s[j] = e.data[W-1-j];
                        check(nm("bit_count"), nbits, W);
                        check(nm("bit_stream"), got, exp_s);
                        check(nm("sr_out_word"), sr_out, e.data);
                        check(nm("sr_dir_word"), sr_dir, e.dir);
                        $display("g%0d word data=%h dir=%0d out=%h bits=%0d",
                                 G, e.data, e.dir, sr_out, nbits);
                     end
                  end
                  nbits = 0;
               end
               prev_done = done;
            end
         end
      end

      // Offer a word, wait (bounded) for in_ready, then check the first serial bit.
      task automatic send(input logic [W-1:0] d, input logic dr, output int waited);
         exp_t e;
         in_data  = d;
         in_dir   = dr;
         in_valid = 1'b1;
         waited   = 0;
         while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
         end
         if (waited >= 100) begin
            check(nm("accept_timeout"), 1, 0);
         end else begin
            e.data = d;
            e.dir  = dr;
            sb.push_back(e);
         end
         @(negedge clk);
         in_valid = 1'b0;
         check(nm("accept_flags"), {busy, in_ready, sr_en, sr_dir}, {3'b101, dr});
         check(nm("first_bit"), sr_d, dr ? d[0] : d[W-1]);
      endtask

      // Called while bit 0 is on sr_d: checks enable length, the done edge and the gap.
      task automatic word_timing(output int gap_low);
         int n, g;
         bit stop;
         n = 1;
         stop = 1'b0;
         while (!stop) begin
            @(negedge clk);
            if (sr_en && n <= W + 4) n++;
            else stop = 1'b1;
         end
         check(nm("en_cycles"), n, W);
         check(nm("word_end"), {done, busy, in_ready, sr_d},
               {1'b1, (G != 0), (G == 0), 1'b0});
         g = 0;
         while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
         end
         check(nm("gap_cycles"), g, G);
         gap_low = g + 1;
      endtask

      initial begin
         int wt, low, k, n;
         logic [W-1:0] d;
         logic dr;
         rstn = 1'b1;
         flush = 1'b0;
         in_valid = 1'b0;
         in_data = '0;
         in_dir = 1'b0;
         #1 rstn = 1'b0;
         #1 check(nm("reset_outputs"), {sr_d, sr_en, sr_dir, busy, done, in_ready}, 6'b0);
         repeat (2) begin
            @(negedge clk);
            check(nm("reset_held"), {sr_d, sr_en, sr_dir, busy, done, in_ready}, 6'b0);
         end
         rstn = 1'b1;
         #1 check(nm("ready_before_edge"), in_ready, 1'b0);
         @(negedge clk);
         check(nm("ready_after_release"), {in_ready, busy}, 2'b10);

         send(16'hA5C3, 1'b0, wt);
         word_timing(low);
         send(16'h0001, 1'b1, wt);
         word_timing(low);

         // Two queued words with in_valid held high through the busy period.
         send(16'h1234, 1'b0, wt);
         in_data = 16'hF00F;
         in_dir = 1'b1;
         in_valid = 1'b1;
         word_timing(low);
         check(nm("queued_low_cycles"), low, G + 1);
         send(16'hF00F, 1'b1, wt);
         check(nm("queued_accept_wait"), wt, 0);
         word_timing(low);

         // Flush at bit 7, with an in_valid pulse during the busy period.
         send(16'hFFFF, 1'b0, wt);
         repeat (3) @(negedge clk);
         in_data = 16'h1111;
         in_dir = 1'b1;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (3) @(negedge clk);
         flush = 1'b1;
         sb.delete();
         @(negedge clk);
         flush = 1'b0;
         check(nm("flush_end"), {sr_en, sr_d, done, busy, in_ready}, 5'b00001);
         @(negedge clk);
         check(nm("flush_no_capture"), {busy, in_ready, sr_en}, 3'b010);

         // Flush in idle beats a simultaneous offer.
         in_data = 16'h2222;
         in_dir = 1'b0;
         in_valid = 1'b1;
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         in_valid = 1'b0;
         check(nm("flush_idle_priority"), {busy, in_ready, sr_en}, 3'b010);

         // Flush on the done cycle: ends the gap early or is a no-op in idle.
         send(16'h3C5A, 1'b1, wt);
         n = 0;
         while (sr_en && n < 40) begin
            @(negedge clk);
            n++;
         end
         check(nm("flush_done_seen"), done, 1'b1);
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         check(nm("flush_after_done"), {busy, in_ready, done, sr_en, sr_dir}, 5'b01001);

         // Asynchronous reset in the middle of bit 9.
         send(16'hC3C3, 1'b1, wt);
         repeat (9) @(negedge clk);
         #2 rstn = 1'b0;
         sb.delete();
         #1 check(nm("async_reset"), {sr_d, sr_en, sr_dir, busy, done, in_ready}, 6'b0);
         repeat (2) @(negedge clk);
         rstn = 1'b1;
         @(negedge clk);
         check(nm("ready_after_rereset"), in_ready, 1'b1);
         send(16'h5AA5, 1'b0, wt);
         word_timing(low);

         // Random words, idle spacing and occasional flushes.
         for (int i = 0; i < 24; i++) begin
            d = W'($urandom);
            dr = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d, dr, wt);
            if ($urandom_range(0, 5) == 0) begin
               k = $urandom_range(1, W - 1);
               repeat (k) @(negedge clk);
               flush = 1'b1;
               sb.delete();
               @(negedge clk);
               flush = 1'b0;
               check(nm("rand_flush"), {sr_en, done, busy, in_ready}, 4'b0001);
            end else begin
               word_timing(low);
            end
         end
         repeat (3) @(negedge clk);
         check(nm("scoreboard_drained"), sb.size(), 0);
         fin_cnt++;
      end
   end

   initial begin
      int t;
      t = 0;
      while (fin_cnt < 2 && t < 20000) begin
         @(posedge clk);
         t++;
      end
      if (fin_cnt < 2) begin
         total++;
         bad++;
         $display("FAIL run_timeout: finished=%0d want 2", fin_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sr_word_serializer.md
Name: sr_word_serializer

Overview:
- Upstream feeder for the bidirectional serial shift register `shift_reg`.
- Accepts a parallel word over a valid/ready handshake.
- Drives the register's serial inputs (`d`, `en`, `dir`) one bit per clock, in the order that leaves the word intact in the register's parallel `out`.
- Signals completion with a one-cycle `done` pulse, then waits a programmable idle gap before accepting the next word.

Parameters:
- WIDTH, 16, word length in bits; must equal the downstream shift_reg MSB parameter; legal range >= 2.
- GAP, 0, idle cycles inserted after `done` before `in_ready` reasserts; legal range 0..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_dir  input  1  direction tag for the word; 0 = left shift, 1 = right shift.
- in_valid  input  1  source offers in_data/in_dir.
- in_ready  output  1  block can accept a word.
- flush  input  1  synchronous abort of the word in flight.
- sr_d  output  1  serial bit; connects to shift_reg d.
- sr_en  output  1  shift enable; connects to shift_reg en.
- sr_dir  output  1  direction; connects to shift_reg dir.
- busy  output  1  word in flight or gap in progress.
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Downstream shift_reg convention, decided:
  - dir=0: the new bit enters bit 0 and the contents shift toward the MSB.
  - dir=1: the new bit enters the MSB and the contents shift toward bit 0.
- Reset (rstn=0): takes effect immediately, without waiting for a clock edge.
  - State = IDLE.
  - sr_d=0, sr_en=0, sr_dir=0, busy=0, done=0, in_ready=0.
  - Hold register and bit counter cleared.
- All outputs are registered. in_ready rises on the first rising edge after rstn deasserts.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - On an edge E0 with in_valid=1 and in_ready=1:
    - capture in_data and in_dir;
    - counter=0, go to SHIFT;
    - in_ready=0, busy=1.
- SHIFT, bit k = 0..WIDTH-1, outputs updated at edge E0+k:
  - sr_en=1 and sr_dir = captured dir.
  - sr_d = word[WIDTH-1-k] when dir=0 (MSB first).
  - sr_d = word[k] when dir=1 (LSB first).
  - The downstream register samples each bit at the following edge.
- At edge E0+WIDTH:
  - sr_en=0, sr_d=0, done=1 for exactly one cycle.
  - If GAP=0: busy=0 and in_ready=1 at the same edge.
  - Otherwise go to GAP.
- GAP:
  - Counts GAP cycles with sr_en=0.
  - At edge E0+WIDTH+GAP: busy=0, in_ready=1, state IDLE.
- Minimum accept-to-accept spacing is WIDTH+GAP+1 edges.
- sr_dir holds its last value while idle; it changes only on accept.
- in_valid while in_ready=0 is ignored. The source must hold in_data/in_dir until the handshake completes.
- flush=1 during SHIFT or GAP, at the next edge:
  - sr_en=0, sr_d=0, done stays 0;
  - busy=0, in_ready=1, state IDLE.
- flush=1 in IDLE has no effect, and it takes priority over a simultaneous accept, so no word is captured.
- Counter width: clog2(WIDTH+1) bits, or 8 bits for GAP, whichever is larger. The counter never wraps within a word.
- Reset asserted mid-word discards the word and applies the reset values immediately. No done pulse is produced.

Test Plan:
1. Reset behaviour: hold rstn=0 for 2 cycles, then release. During reset all outputs are 0; in_ready=1 after the first edge following release.
2. WIDTH=16, GAP=0, in_dir=0, in_data=16'hA5C3.
   - sr_en is high for exactly 16 cycles.
   - sr_d sequence is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
   - shift_reg out=16'hA5C3 after the last bit.
   - done is high for 1 cycle.
3. in_dir=1, in_data=16'h0001.
   - sr_dir=1 and the first sr_d bit is 1, followed by 15 zeros.
   - shift_reg out=16'h0001.
4. GAP=3, in_valid held high with two queued words (16'h1234 dir0, then 16'hF00F dir1).
   - Exactly 4 sr_en-low cycles between the two words.
   - The second word is accepted at the edge where in_ready is first high.
   - Final out=16'hF00F.
5. flush asserted during bit 7 of 16'hFFFF.
   - sr_en=0 at the next edge, no done pulse, in_ready=1 at that same edge.
   - in_valid pulsed during the busy period before the flush was not captured.
6. rstn asserted during bit 9 of a word: outputs are zero immediately, without waiting for a clock edge. After release, a new word 16'h5AA5 with dir0 transfers correctly.
